// File: rtl/alu_multicycle.sv
// Registered ALU: single-cycle add/sub/and/or/sll/sra, iterative signed mul/div over WIDTH cycles.
// Latency 1 edge for single-cycle ops, WIDTH+1 edges for mul/div; in_ready low while iterating.
module alu_multicycle #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               ctrl_reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic               out_valid,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               data_exception
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t state, state_nxt;

    logic [SHAMT_W-1:0]   cnt;
    logic                 accept, last;
    logic                 ne_pend, lt_pend;

    logic [WIDTH-1:0]     add_res, sub_res, sc_res;
    logic                 sc_exc, lt_now, b_zero;
    logic [WIDTH-1:0]     a_mag, b_mag;

    logic [2*WIDTH-1:0]   mul_acc, mul_mcand, mul_term, mul_acc_nxt;
    logic [WIDTH-1:0]     mul_mplier;
    logic                 mul_ovf;

    logic [WIDTH-1:0]     div_rem, div_quot, div_dvs, div_rem_nxt, div_quot_nxt;
    logic [WIDTH:0]       div_sh, div_dif;
    logic                 div_neg, div_ovf;

    assign in_ready = (state == IDLE) & ~ctrl_reset;
    assign accept   = in_valid & in_ready;
    assign last     = (cnt == SHAMT_W'(WIDTH - 1));
    assign b_zero   = (data_operandB == '0);
    assign lt_now   = $signed(data_operandA) < $signed(data_operandB);
    assign add_res  = data_operandA + data_operandB;
    assign sub_res  = data_operandA - data_operandB;
    assign a_mag    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (ctrl_ALUopcode == 5'd6)                 state_nxt = MUL;
                else if (ctrl_ALUopcode == 5'd7 && !b_zero) state_nxt = DIV;
            end
            MUL, DIV: if (last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Divide-by-zero and illegal opcodes share the default arm: result 0, exception 1.
    always_comb begin
        sc_res = '0;
        sc_exc = 1'b0;
        case (ctrl_ALUopcode)
            5'd0: begin
                sc_res = add_res;
                sc_exc = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                         (add_res[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            5'd1: begin
                sc_res = sub_res;
                sc_exc = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                         (sub_res[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            5'd2:    sc_res = data_operandA & data_operandB;
            5'd3:    sc_res = data_operandA | data_operandB;
            5'd4:    sc_res = data_operandA << ctrl_shiftamt;
            5'd5:    sc_res = $signed(data_operandA) >>> ctrl_shiftamt;
            default: begin
                sc_res = '0;
                sc_exc = 1'b1;
            end
        endcase
    end

    // Two's-complement shift-add: the multiplier's sign bit carries weight -2^(WIDTH-1).
    always_comb begin
        mul_term    = mul_mplier[0] ? mul_mcand : '0;
        mul_acc_nxt = last ? (mul_acc - mul_term) : (mul_acc + mul_term);
        mul_ovf     = !((&mul_acc_nxt[2*WIDTH-1:WIDTH-1]) || (~|mul_acc_nxt[2*WIDTH-1:WIDTH-1]));
    end

    always_comb begin
        div_sh       = {div_rem, div_quot[WIDTH-1]};
        div_dif      = div_sh - {1'b0, div_dvs};
        div_rem_nxt  = div_dif[WIDTH] ? div_sh[WIDTH-1:0] : div_dif[WIDTH-1:0];
        div_quot_nxt = {div_quot[WIDTH-2:0], ~div_dif[WIDTH]};
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            out_valid      <= 1'b0;
            data_result    <= '0;
            isNotEqual     <= 1'b0;
            isLessThan     <= 1'b0;
            data_exception <= 1'b0;
            cnt            <= '0;
            ne_pend        <= 1'b0;
            lt_pend        <= 1'b0;
            mul_acc        <= '0;
            mul_mcand      <= '0;
            mul_mplier     <= '0;
            div_rem        <= '0;
            div_quot       <= '0;
            div_dvs        <= '0;
            div_neg        <= 1'b0;
            div_ovf        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    cnt     <= '0;
                    ne_pend <= (data_operandA != data_operandB);
                    lt_pend <= lt_now;
                    if (ctrl_ALUopcode == 5'd6) begin
                        mul_acc    <= '0;
                        mul_mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
                        mul_mplier <= data_operandB;
                    end else if (ctrl_ALUopcode == 5'd7 && !b_zero) begin
                        div_rem  <= '0;
                        div_quot <= a_mag;
                        div_dvs  <= b_mag;
                        div_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                    (&data_operandB);
                    end else begin
                        out_valid      <= 1'b1;
                        data_result    <= sc_res;
                        data_exception <= sc_exc;
                        isNotEqual     <= (data_operandA != data_operandB);
                        isLessThan     <= lt_now;
                    end
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (state == MUL) begin
                    mul_acc    <= mul_acc_nxt;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                end else begin
                    div_rem  <= div_rem_nxt;
                    div_quot <= div_quot_nxt;
                end
                if (last) begin
                    out_valid      <= 1'b1;
                    isNotEqual     <= ne_pend;
                    isLessThan     <= lt_pend;
                    data_result    <= (state == MUL) ? mul_acc_nxt[WIDTH-1:0]
                                    : (div_neg ? -div_quot_nxt : div_quot_nxt);
                    data_exception <= (state == MUL) ? mul_ovf : div_ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomized checks of alu_multicycle against a 64-bit arithmetic reference model.
module tb_alu_multicycle;

    logic        clock;
    logic        ctrl_reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [4:0]  ctrl_ALUopcode;
    logic [4:0]  ctrl_shiftamt;
    logic        out_valid;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        data_exception;

    int tests = 0;
    int fails = 0;

    alu_multicycle #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .out_valid      (out_valid),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .data_exception (data_exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit out_of_range(input longint p);
        return (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endfunction

    // Reference: plain wide-integer arithmetic on the signed operand values.
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output logic e,
                                  output int lat);
        longint sa, sb, p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        p   = 0;
        lat = 1;
        e   = 1'b0;
        r   = '0;
        case (op)
            5'd0: begin p = sa + sb; r = p[31:0]; e = out_of_range(p); end
            5'd1: begin p = sa - sb; r = p[31:0]; e = out_of_range(p); end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a << sh;
            5'd5: r = $signed(a) >>> sh;
            5'd6: begin p = sa * sb; r = p[31:0]; e = out_of_range(p); lat = 33; end
            5'd7: begin
                if (b == 32'd0) begin
                    r = '0;
                    e = 1'b1;
                end else begin
                    p   = sa / sb;
                    r   = p[31:0];
                    e   = out_of_range(p);
                    lat = 33;
                end
            end
            default: begin r = '0; e = 1'b1; end
        endcase
    endfunction

    // Entered at a negedge; leaves at the negedge after the result is checked.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] er;
        logic        ee;
        int          lat;
        int          edges;
        bit          busy_ok;
        model(op, a, b, sh, er, ee, lat);
        in_valid       = 1'b1;
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = sh;
        @(posedge clock); #1;
        edges          = 1;
        busy_ok        = 1'b1;
        in_valid       = 1'b0;
        data_operandA  = $urandom;
        data_operandB  = $urandom;
        ctrl_ALUopcode = 5'($urandom);
        ctrl_shiftamt  = 5'($urandom);
        while (!out_valid && edges < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(negedge clock);
            in_valid       = 1'($urandom_range(0, 1));
            ctrl_ALUopcode = 5'($urandom_range(0, 5));
            @(posedge clock); #1;
            edges++;
            in_valid = 1'b0;
        end
        check({tag, " latency"}, edges, lat);
        check({tag, " out_valid"}, out_valid, 1'b1);
        check({tag, " busy in_ready"}, busy_ok, 1'b1);
        check({tag, " in_ready"}, in_ready, 1'b1);
        check({tag, " result"}, data_result, er);
        check({tag, " exception"}, data_exception, ee);
        check({tag, " isLessThan"}, isLessThan, $signed(a) < $signed(b));
        check({tag, " isNotEqual"}, isNotEqual, a != b);
        @(negedge clock);
    endtask

    task automatic idle_check(input string tag);
        logic [31:0] held;
        held = data_result;
        @(posedge clock); #1;
        check({tag, " pulse ends"}, out_valid, 1'b0);
        check({tag, " result held"}, data_result, held);
        @(negedge clock);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 40)) - 32'd20;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [4:0]  op;
        bit          spurious;
        ctrl_reset     = 1'b1;
        in_valid       = 1'b0;
        data_operandA  = '0;
        data_operandB  = '0;
        ctrl_ALUopcode = '0;
        ctrl_shiftamt  = '0;
        #2;
        check("reset in_ready", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset result", data_result, 32'd0);
        check("reset flags", {isNotEqual, isLessThan, data_exception}, 3'b000);
        repeat (2) @(negedge clock);
        ctrl_reset = 1'b0;
        #1;
        check("release in_ready", in_ready, 1'b1);
        @(negedge clock);

        run_op("add ovf", 5'd0, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("add ovf const", {data_exception, data_result}, {1'b1, 32'h8000_0000});
        run_op("sub b2b", 5'd1, 32'd5, 32'd7, 5'd0);
        check("sub b2b const", {data_exception, isLessThan, isNotEqual, data_result},
              {3'b011, 32'hFFFF_FFFE});
        idle_check("sub");

        run_op("sll 31", 5'd4, 32'd1, 32'd0, 5'd31);
        check("sll const", data_result, 32'h8000_0000);
        run_op("sra 4", 5'd5, 32'h8000_0000, 32'd0, 5'd4);
        check("sra const", data_result, 32'hF800_0000);
        run_op("sra 0", 5'd5, 32'h9ABC_DEF0, 32'd0, 5'd0);
        run_op("and", 5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
        run_op("or", 5'd3, 32'hF0F0_1234, 32'h0F00_0001, 5'd0);

        run_op("mul -3*7", 5'd6, -32'sd3, 32'd7, 5'd0);
        check("mul const", {data_exception, data_result}, {1'b0, 32'hFFFF_FFEB});
        idle_check("mul");
        run_op("mul ovf", 5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0);
        check("mul ovf exc", data_exception, 1'b1);

        run_op("div -7/2", 5'd7, -32'sd7, 32'd2, 5'd0);
        check("div const", data_result, 32'hFFFF_FFFD);
        run_op("div by 0", 5'd7, 32'd5, 32'd0, 5'd0);
        run_op("div min/-1", 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        check("div min const", {data_exception, data_result}, {1'b1, 32'h8000_0000});

        run_op("cmp min<1", 5'd0, 32'h8000_0000, 32'd1, 5'd0);
        check("cmp lt const", isLessThan, 1'b1);
        run_op("cmp equal", 5'd2, 32'h1234, 32'h1234, 5'd0);
        run_op("illegal 12", 5'd12, 32'h55, 32'h66, 5'd3);

        // Reset ten cycles into a multiply must discard it silently.
        in_valid       = 1'b1;
        ctrl_ALUopcode = 5'd6;
        data_operandA  = 32'd9;
        data_operandB  = 32'd9;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b1;
        #1;
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset result", data_result, 32'd0);
        check("midreset flags", {isNotEqual, isLessThan, data_exception}, 3'b000);
        check("midreset in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clock);
        ctrl_reset = 1'b0;
        #1;
        check("post reset in_ready", in_ready, 1'b1);
        spurious = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) spurious = 1'b1;
        end
        check("discarded op silent", spurious, 1'b0);
        @(negedge clock);
        run_op("add 2+2", 5'd0, 32'd2, 32'd2, 5'd0);
        check("add 2+2 const", data_result, 32'd4);

        for (int i = 0; i < 60; i++) begin
            op = 5'($urandom_range(0, 9));
            if (op > 5'd7) op = 5'($urandom_range(8, 31));
            a = rand_operand();
            b = ($urandom_range(0, 7) == 0) ? a : rand_operand();
            run_op($sformatf("rand%0d op%0d", i, op), op, a, b, 5'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the single-cycle processor ALU. It adds signed multiply and divide, executed iteratively over WIDTH cycles, to the existing add/sub/and/or/sll/sra operations. Operations enter through a valid/ready handshake, and results come back with a one-cycle valid pulse, so the execute stage can stall on long ops. isNotEqual/isLessThan are produced for every accepted operation.

## Interface
- WIDTH, 32, operand/result width in bits (≥8, power of two)
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH)
- clock  in  1  single clock; all state updates on rising edge
- ctrl_reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; transfer when in_valid & in_ready at a rising edge
- data_operandA  in  WIDTH  signed operand A
- data_operandB  in  WIDTH  signed operand B
- ctrl_ALUopcode  in  5  0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra, 6 mul, 7 div; 8–31 illegal
- ctrl_shiftamt  in  SHAMT_W  shift distance for opcodes 4/5
- out_valid  out  1  one-cycle pulse: result registers updated
- data_result  out  WIDTH  registered result, held until next out_valid
- isNotEqual  out  1  registered A != B of the accepted op
- isLessThan  out  1  registered signed A < B of the accepted op
- data_exception  out  1  registered exception flag, qualified by out_valid

## Operation
- FSM states: IDLE, MUL, DIV. in_ready = (state == IDLE) & ~ctrl_reset.
- All operands and opcode are captured at the accepting edge. Inputs are don't-care afterwards.
- Opcodes 0–5 and illegal opcodes stay in IDLE. Results register at the accepting edge.
- add/sub wrap modulo 2^WIDTH. exception = signed overflow.
- and/or: exception 0.
- sll: logical left shift. sra: arithmetic right shift. Shift distance 0 passes A unchanged. exception 0.
- Illegal opcode: result 0, exception 1.
- isLessThan is true signed compare, correct under subtraction overflow (e.g. A=0x80000000, B=1 → 1). isNotEqual = (A != B). Both are updated for every accepted op, including mul/div, at the out_valid edge.
- mul (6): IDLE→MUL. Signed shift-add over WIDTH iterations, one per cycle. result = low WIDTH bits of 2·WIDTH-bit product. exception = 1 iff the product is not representable in signed WIDTH.
- div (7): restoring division on magnitudes over WIDTH iterations, then sign fix. Quotient truncates toward zero.
  - B == 0: no iteration; result 0, exception 1, 1-cycle latency.
  - A == MIN and B == −1: result MIN, exception 1, full latency.
- MUL/DIV→IDLE after the final iteration, asserting out_valid that cycle.
- Reset, including mid-operation: FSM→IDLE; the in-flight op is discarded with no out_valid. out_valid, data_result, isNotEqual, isLessThan, data_exception all reset to 0. in_ready is 0 while reset is asserted and 1 after release.

## Timing
- Single-cycle class (0–5, illegal, div-by-zero): accepted at edge t, out_valid high after edge t, for one cycle. in_ready stays 1, so back-to-back accepts give out_valid every cycle.
- mul/div: accepted at edge t. in_ready low after t. out_valid and in_ready go high after edge t+WIDTH. A new op can be accepted at edge t+WIDTH+1.
- Mul/div latency is exactly WIDTH+1 edges from accept to out_valid, independent of operand values.
- Without an accept, out_valid is 0 and all result registers hold.
- in_valid while in_ready = 0 is ignored. The requester holds the request, and no request is queued.

## Test plan
- Reset then add 0x7FFFFFFF + 1 → out_valid 1 cycle later, result 0x80000000, exception 1. Then back-to-back sub 5−7 the next cycle → 0xFFFFFFFE, exception 0, isLessThan 1, isNotEqual 1.
- sll 0x00000001 by 31 → 0x80000000. sra 0x80000000 by 4 → 0xF8000000. sra by 0 → operand unchanged.
- mul −3 × 7: in_ready low for 32 cycles, out_valid at edge 33, result 0xFFFFFFEB, exception 0. mul 0x10000 × 0x10000 → 0, exception 1.
- div −7 / 2 → 0xFFFFFFFD at latency 33. div 5 / 0 → 0, exception 1, latency 1. div 0x80000000 / −1 → 0x80000000, exception 1.
- Compare: A=0x80000000, B=1 → isLessThan 1. A=B=0x1234 → isLessThan 0, isNotEqual 0. Opcode 12 → result 0, exception 1.
- Assert ctrl_reset 10 cycles into a mul → outputs 0 immediately, no out_valid. After release, in_ready is 1 and add 2+2 → 4.
